sclk_burst_gen: RTL and testbench
=================================

SCLK_BURST_GEN -- requirements
Module: sclk_burst_gen

Interface
REQ-001 The module SHALL have parameter DIV_W, default 8, the width of the divider value and the half-period counter.
REQ-002 The module SHALL have parameter CNT_W, default 8, the width of the burst clock-count field.
REQ-003 Port i_sysclk, input, 1 bit: system clock; all logic SHALL be on its rising edge.
REQ-004 Port i_sysrst, input, 1 bit: system reset, asynchronous and active-high.
REQ-005 Port i_mod_en, input, 1 bit: module enable; when low, the module aborts and holds idle.
REQ-006 Port i_ld, input, 1 bit: load divider value strobe.
REQ-007 Port i_ld_data, input, DIV_W bits: divider value; half-period = i_ld_data+1 sysclk cycles.
REQ-008 Port i_cpol, input, 1 bit: idle level of sclk, latched at burst start.
REQ-009 Port i_start, input, 1 bit: burst start request.
REQ-010 Port i_nclk, input, CNT_W bits: number of full sclk periods in the burst, latched at start.
REQ-011 Port o_sclk, output, 1 bit: generated serial clock.
REQ-012 Port o_sclk_rise, output, 1 bit: one-cycle pulse in the cycle before o_sclk goes 0->1.
REQ-013 Port o_sclk_fall, output, 1 bit: one-cycle pulse in the cycle before o_sclk goes 1->0.
REQ-014 Port o_busy, output, 1 bit: high while the state is RUN.
REQ-015 Port o_done, output, 1 bit: one-cycle pulse on burst completion.

Function
REQ-016 The module SHALL update r_div from i_ld_data on a cycle with i_ld=1 and state IDLE; i_ld SHALL be ignored in RUN.
REQ-017 The FSM SHALL have two states, IDLE and RUN.
REQ-018 IDLE->RUN SHALL occur on i_start=1, i_mod_en=1 and i_nclk!=0; this cycle latches cpol and i_nclk and clears the counter.
REQ-019 If i_start=1 and i_mod_en=1 with i_nclk=0 in IDLE, the module SHALL stay IDLE, pulse o_done next cycle and generate no edges.
REQ-020 i_start in RUN SHALL be ignored.
REQ-021 In RUN, the counter SHALL increment each cycle and wrap to 0 when it equals r_div; this is the terminal count (tc).
REQ-022 At each tc, r_sclk SHALL toggle.
REQ-023 The first toggle SHALL be away from cpol (leading edge); the return to cpol (trailing edge) SHALL decrement the remaining count.
REQ-024 o_sclk_rise SHALL be asserted in the tc cycle where r_sclk=0, and o_sclk_fall in the tc cycle where r_sclk=1; both are combinational and are 0 outside RUN.
REQ-025 When the trailing edge takes the remaining count from 1 to 0, the FSM SHALL go to IDLE and o_done SHALL pulse for exactly one cycle in the following cycle.
REQ-026 Latency: for a start accepted at cycle T, the counter SHALL be 0 at T+1 and the first edge pulse SHALL occur at T+1+r_div.
REQ-027 Burst length SHALL be 2*nclk*(r_div+1) cycles in RUN.
REQ-028 i_mod_en=0 in any state SHALL force IDLE next cycle, with counter=0, r_sclk=latched cpol and no o_done.
REQ-029 While i_mod_en=0, pulse outputs SHALL be 0.
REQ-030 In IDLE, o_sclk SHALL equal the latched cpol.
REQ-031 Counter and count widths SHALL wrap modulo 2^DIV_W and 2^CNT_W with no overflow beyond them.
REQ-032 r_div=0 SHALL give a toggle on every cycle, i.e. sclk = sysclk/2.

Reset
REQ-033 Asserting i_sysrst SHALL immediately force IDLE, r_div=0, counter=0, remaining count=0, latched cpol=0, o_sclk=0, o_busy=0, o_done=0, o_sclk_rise=0 and o_sclk_fall=0.
REQ-034 Reset asserted mid-burst SHALL abort the burst with no o_done.

Verification
REQ-035 ld 3, cpol=0, nclk=2, start -> o_busy for 16 cycles; 2 rise and 2 fall pulses each 4 cycles apart; o_sclk high 4 cycles, low 4 cycles; o_done one cycle; o_sclk ends at 0.
REQ-036 cpol=1, div=0, nclk=3 -> o_sclk idles at 1; fall pulse first; 6 edges on consecutive cycles; o_done after the 3rd rise.
REQ-037 start with nclk=0 -> no edges, o_busy stays 0, o_done pulses once.
REQ-038 i_mod_en dropped mid-burst -> next cycle IDLE, o_sclk=cpol, no o_done; a fresh start then runs a full burst.
REQ-039 i_ld=1 with new data and a second i_start during RUN -> both ignored, period unchanged; the new load takes effect after returning to IDLE.
REQ-040 async i_sysrst pulse mid-burst, between clock edges -> outputs 0 immediately, r_div=0.

Source files
------------

// File: rtl/sclk_burst_gen.sv
// Serial-clock burst generator: emits nclk full sclk periods of 2*(div+1) sysclk cycles,
// idling at a per-burst polarity, with pre-edge rise/fall strobes and a completion pulse.
module sclk_burst_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             i_sysclk,
  input  logic             i_sysrst,
  input  logic             i_mod_en,
  input  logic             i_ld,
  input  logic [DIV_W-1:0] i_ld_data,
  input  logic             i_cpol,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_nclk,
  output logic             o_sclk,
  output logic             o_sclk_rise,
  output logic             o_sclk_fall,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             cpol_q, cpol_d;
  logic             sclk_q, sclk_d;
  logic             done_q, done_d;
  logic             run;
  logic             tc;
  logic             trailing;

  assign run      = (state_q == ST_RUN);
  assign tc       = run && (cnt_q == div_q);
  // sclk away from cpol means the next toggle returns to idle level
  assign trailing = (sclk_q != cpol_q);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    cpol_d  = cpol_q;
    sclk_d  = sclk_q;
    done_d  = 1'b0;

    if (!run && i_ld) begin
      div_d = i_ld_data;
    end

    if (!i_mod_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      rem_d   = '0;
      sclk_d  = cpol_q;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            if (i_nclk != '0) begin
              state_d = ST_RUN;
              cpol_d  = i_cpol;
              rem_d   = i_nclk;
              cnt_d   = '0;
              sclk_d  = i_cpol;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          cnt_d = tc ? '0 : cnt_q + DIV_W'(1);
          if (tc) begin
            sclk_d = ~sclk_q;
            if (trailing) begin
              rem_d = rem_q - CNT_W'(1);
              if (rem_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sysclk or posedge i_sysrst) begin
    if (i_sysrst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      cpol_q  <= 1'b0;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      cpol_q  <= cpol_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
    end
  end

  assign o_sclk      = sclk_q;
  assign o_busy      = run;
  assign o_sclk_rise = tc && !sclk_q && i_mod_en;
  assign o_sclk_fall = tc && sclk_q && i_mod_en;
  assign o_done      = done_q && i_mod_en;

endmodule

// File: tb/tb_sclk_burst_gen.sv
// Bench for sclk_burst_gen: closed-form burst model checked every cycle, plus directed scenarios.
module tb_sclk_burst_gen;

  logic       clk;
  logic       rst;
  logic       mod_en;
  logic       ld;
  logic [7:0] ld_data;
  logic       cpol;
  logic       start;
  logic [7:0] nclk;
  logic       sclk, rise, fall, busy, done;

  int total = 0;
  int bad   = 0;

  sclk_burst_gen #(.DIV_W(8), .CNT_W(8)) dut (
    .i_sysclk   (clk),
    .i_sysrst   (rst),
    .i_mod_en   (mod_en),
    .i_ld       (ld),
    .i_ld_data  (ld_data),
    .i_cpol     (cpol),
    .i_start    (start),
    .i_nclk     (nclk),
    .o_sclk     (sclk),
    .o_sclk_rise(rise),
    .o_sclk_fall(fall),
    .o_busy     (busy),
    .o_done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: a burst is described by its start-relative cycle index k (1..2*n*(div+1))
  int m_div, m_cpol, m_busy, m_k, m_n, m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_div = 0; m_cpol = 0; m_busy = 0; m_k = 0; m_n = 0; m_done = 0;
    end else begin
      if (!mod_en) begin
        if (!m_busy && ld) m_div = ld_data;
        m_busy = 0;
        m_done = 0;
      end else if (m_busy) begin
        m_done = 0;
        if (m_k == 2 * m_n * (m_div + 1)) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_k++;
        end
      end else begin
        m_done = 0;
        if (ld) m_div = ld_data;
        if (start) begin
          if (nclk != 0) begin
            m_busy = 1; m_k = 1; m_n = nclk; m_cpol = cpol;
          end else begin
            m_done = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    int half, e_sclk, e_tc, e_lead_rise, e_rise, e_fall, e_done;
    half        = m_div + 1;
    e_sclk      = m_busy ? (m_cpol ^ (((m_k - 1) / half) % 2)) : m_cpol;
    e_tc        = (m_busy != 0) && (m_k % half == 0);
    e_lead_rise = (((m_k / half) % 2) == 1) == (m_cpol == 0);
    e_rise      = e_tc && mod_en && e_lead_rise;
    e_fall      = e_tc && mod_en && !e_lead_rise;
    e_done      = (m_done != 0) && mod_en;
    chk("cyc_sclk", sclk, e_sclk);
    chk("cyc_busy", busy, m_busy);
    chk("cyc_rise", rise, e_rise);
    chk("cyc_fall", fall, e_fall);
    chk("cyc_done", done, e_done);
  end

  int w_busy, w_rise, w_fall, w_done, w_high, first_rise, first_fall, done_idx, last_sclk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic window(input int n);
    w_busy = 0; w_rise = 0; w_fall = 0; w_done = 0; w_high = 0;
    first_rise = 0; first_fall = 0; done_idx = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      w_busy += busy;
      w_high += sclk;
      if (rise) begin w_rise++; if (first_rise == 0) first_rise = i; end
      if (fall) begin w_fall++; if (first_fall == 0) first_fall = i; end
      if (done) begin w_done++; if (done_idx == 0) done_idx = i; end
    end
    last_sclk = sclk;
  endtask

  task automatic load(input int v);
    tick();
    ld = 1'b1; ld_data = 8'(v);
    tick();
    ld = 1'b0;
  endtask

  task automatic go(input int c, input int n);
    tick();
    cpol = c[0]; nclk = 8'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mod_en = 1'b1; ld = 1'b0; ld_data = '0;
    cpol = 1'b0; start = 1'b0; nclk = '0;
    #12;
    chk("rst_sclk", sclk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick();
    rst = 1'b0;

    // div 3, two periods from idle-low
    load(3);
    go(0, 2);
    window(22);
    chk("b1_busy", w_busy, 16);
    chk("b1_rise", w_rise, 2);
    chk("b1_fall", w_fall, 2);
    chk("b1_first_rise", first_rise, 4);
    chk("b1_first_fall", first_fall, 8);
    chk("b1_high", w_high, 8);
    chk("b1_done_cnt", w_done, 1);
    chk("b1_done_idx", done_idx, 17);
    chk("b1_end_sclk", last_sclk, 0);

    // div 0, idle-high, three periods
    load(0);
    go(1, 3);
    window(10);
    chk("b2_busy", w_busy, 6);
    chk("b2_fall", w_fall, 3);
    chk("b2_rise", w_rise, 3);
    chk("b2_first_fall", first_fall, 1);
    chk("b2_first_rise", first_rise, 2);
    chk("b2_done_idx", done_idx, 7);
    chk("b2_end_sclk", last_sclk, 1);

    // zero-length burst
    go(0, 0);
    window(4);
    chk("b3_busy", w_busy, 0);
    chk("b3_edges", w_rise + w_fall, 0);
    chk("b3_done_cnt", w_done, 1);
    chk("b3_done_idx", done_idx, 1);

    // enable dropped mid-burst, then a fresh burst
    load(3);
    go(1, 2);
    window(6);
    tick();
    mod_en = 1'b0;
    tick();
    mod_en = 1'b1;
    window(20);
    chk("b4_busy", w_busy, 0);
    chk("b4_done", w_done, 0);
    chk("b4_sclk", last_sclk, 1);
    go(1, 2);
    window(22);
    chk("b4_rerun_busy", w_busy, 16);
    chk("b4_rerun_done", w_done, 1);

    // load and start during RUN are ignored; load counts once idle
    go(0, 1);
    tick();
    ld = 1'b1; ld_data = 8'd0; start = 1'b1; nclk = 8'd3;
    tick();
    ld = 1'b0; start = 1'b0;
    window(12);
    chk("b5_busy_rest", w_busy, 6);
    chk("b5_done", w_done, 1);
    load(0);
    go(0, 1);
    window(6);
    chk("b5_newdiv_busy", w_busy, 2);

    // asynchronous reset between clock edges
    load(2);
    go(1, 2);
    window(3);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_sclk", sclk, 0);
    chk("ar_busy", busy, 0);
    chk("ar_rise", rise, 0);
    chk("ar_fall", fall, 0);
    chk("ar_done", done, 0);
    tick();
    rst = 1'b0;
    go(0, 1);
    window(6);
    chk("ar_div0_busy", w_busy, 2);
    chk("ar_div0_first_rise", first_rise, 1);
    chk("ar_div0_done", w_done, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst     = ($urandom_range(0, 599) == 0);
      mod_en  = ($urandom_range(0, 39) != 0);
      ld      = ($urandom_range(0, 7) == 0);
      ld_data = 8'($urandom_range(0, 5));
      start   = ($urandom_range(0, 5) == 0);
      nclk    = 8'($urandom_range(0, 3));
      cpol    = 1'($urandom_range(0, 1));
    end
    tick();
    rst = 1'b0; ld = 1'b0; start = 1'b0; mod_en = 1'b1;
    window(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
